// File: rtl/ma_mem_sequencer_pkg.sv
//==============================================================================
// vcpu32_pkg : shared MA-stage size codes, trap codes and sequencer states
// Rev 1.0
//==============================================================================
`default_nettype none

package vcpu32_pkg;

  localparam logic [1:0] c_SIZE_BYTE = 2'b00;
  localparam logic [1:0] c_SIZE_HALF = 2'b01;
  localparam logic [1:0] c_SIZE_WORD = 2'b10;
  localparam logic [1:0] c_SIZE_ILL  = 2'b11;

  localparam logic [1:0] c_TRAP_NONE     = 2'b00;
  localparam logic [1:0] c_TRAP_MISALIGN = 2'b01;
  localparam logic [1:0] c_TRAP_TIMEOUT  = 2'b10;
  localparam logic [1:0] c_TRAP_ILLEGAL  = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2,
    TRAP = 2'd3
  } ma_seq_state_t;

endpackage

`default_nettype wire

// File: rtl/ma_mem_sequencer_if.sv
//==============================================================================
// ma_mem_sequencer_if : pipeline request/response and memory port bundle
// Rev 1.0
//==============================================================================
`default_nettype none

interface ma_mem_sequencer_if #(parameter int WORD_LENGTH = 32);
  logic                   inReqValid;
  logic                   inReqWrite;
  logic [1:0]             inReqSize;
  logic [WORD_LENGTH-1:0] inReqAdr;
  logic [WORD_LENGTH-1:0] inReqData;
  logic                   inFlush;
  logic                   outStall;
  logic                   outRespValid;
  logic [WORD_LENGTH-1:0] outRespData;
  logic                   outTrap;
  logic [1:0]             outTrapCode;
  logic                   outMemReq;
  logic                   outMemWrite;
  logic [WORD_LENGTH-1:0] outMemAdr;
  logic [3:0]             outMemByteEn;
  logic [WORD_LENGTH-1:0] outMemWData;
  logic                   inMemAck;
  logic [WORD_LENGTH-1:0] inMemRData;

  // Sequencer view
  modport master (
    input  inReqValid, inReqWrite, inReqSize, inReqAdr, inReqData, inFlush,
    input  inMemAck, inMemRData,
    output outStall, outRespValid, outRespData, outTrap, outTrapCode,
    output outMemReq, outMemWrite, outMemAdr, outMemByteEn, outMemWData
  );

  // Pipeline + memory view
  modport slave (
    output inReqValid, inReqWrite, inReqSize, inReqAdr, inReqData, inFlush,
    output inMemAck, inMemRData,
    input  outStall, outRespValid, outRespData, outTrap, outTrapCode,
    input  outMemReq, outMemWrite, outMemAdr, outMemByteEn, outMemWData
  );
endinterface

`default_nettype wire

// File: rtl/ma_byte_lane_align.sv
//==============================================================================
// ma_byte_lane_align : big-endian byte enables, store replication, load extract
// Rev 1.0
//==============================================================================
`default_nettype none

module ma_byte_lane_align
  import vcpu32_pkg::*;
#(
  parameter int WORD_LENGTH = 32
) (
  input  wire logic [1:0]             i_size,
  input  wire logic [1:0]             i_off,
  input  wire logic [WORD_LENGTH-1:0] i_wdata,
  input  wire logic [WORD_LENGTH-1:0] i_rdata,
  output logic      [3:0]             o_byte_en,
  output logic      [WORD_LENGTH-1:0] o_wdata,
  output logic      [WORD_LENGTH-1:0] o_rdata
);

  always_comb begin
    o_byte_en = 4'b1111;
    o_wdata   = i_wdata;
    o_rdata   = '0;
    case (i_size)
      c_SIZE_BYTE: begin
        o_byte_en = 4'b1000 >> i_off;
        o_wdata   = {(WORD_LENGTH/8){i_wdata[7:0]}};
        // Offset 0 is the most significant lane.
        case (i_off)
          2'd0:    o_rdata[7:0] = i_rdata[WORD_LENGTH-1  -: 8];
          2'd1:    o_rdata[7:0] = i_rdata[WORD_LENGTH-9  -: 8];
          2'd2:    o_rdata[7:0] = i_rdata[WORD_LENGTH-17 -: 8];
          default: o_rdata[7:0] = i_rdata[WORD_LENGTH-25 -: 8];
        endcase
      end
      c_SIZE_HALF: begin
        o_byte_en = i_off[1] ? 4'b0011 : 4'b1100;
        o_wdata   = {(WORD_LENGTH/16){i_wdata[15:0]}};
        o_rdata[15:0] = i_off[1] ? i_rdata[WORD_LENGTH-17 -: 16]
                                 : i_rdata[WORD_LENGTH-1  -: 16];
      end
      default: o_rdata = i_rdata;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/ma_mem_sequencer.sv
//==============================================================================
// ma_mem_sequencer : MA-stage load/store sequencer with req/ack memory handshake
// Optional bus timeout trap: define MA_SEQ_TIMEOUT_EN.   Rev 1.0
//==============================================================================
`default_nettype none

module ma_mem_sequencer
  import vcpu32_pkg::*;
#(
  parameter int WORD_LENGTH    = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input wire logic            inClk,
  input wire logic            inRst,
  ma_mem_sequencer_if.master  bus
);

  ma_seq_state_t          r_state, w_next;
  logic                   r_flushed;
  logic                   r_write;
  logic [1:0]             r_size, r_off, r_trap_code;
  logic [WORD_LENGTH-1:2] r_adr;
  logic [WORD_LENGTH-1:0] r_wdata, r_rdata;
  logic [1:0]             w_chk_code;
  logic                   w_accept, w_busy, w_tmo_hit;
  logic [3:0]             w_byte_en;
  logic [WORD_LENGTH-1:0] w_wdata_rep, w_rdata_ext;

  if (TIMEOUT_CYCLES < 1) begin : g_chk_timeout
    $error("TIMEOUT_CYCLES must be at least 1");
  end

  assign w_accept = (r_state == IDLE) & bus.inReqValid & ~bus.inFlush;
  assign w_busy   = (r_state == BUSY);

  always_comb begin
    w_chk_code = c_TRAP_NONE;
    if (bus.inReqSize == c_SIZE_ILL)
      w_chk_code = c_TRAP_ILLEGAL;
    else if (((bus.inReqSize == c_SIZE_HALF) && bus.inReqAdr[0]) ||
             ((bus.inReqSize == c_SIZE_WORD) && (bus.inReqAdr[1:0] != 2'b00)))
      w_chk_code = c_TRAP_MISALIGN;
  end

`ifdef MA_SEQ_TIMEOUT_EN
  localparam int CNT_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
  logic [CNT_W-1:0] r_tmo_cnt;

  // Limit reached on the TIMEOUT_CYCLES-th BUSY cycle; an ack in that cycle wins.
  assign w_tmo_hit = (r_tmo_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge inClk or negedge inRst) begin
    if (!inRst)                         r_tmo_cnt <= '0;
    else if (w_accept)                  r_tmo_cnt <= '0;
    else if (w_busy && !bus.inMemAck)   r_tmo_cnt <= r_tmo_cnt + 1'b1;
  end
`else
  assign w_tmo_hit = 1'b0;
`endif

  ma_byte_lane_align #(.WORD_LENGTH(WORD_LENGTH)) u_lane (
    .i_size    (r_size),
    .i_off     (r_off),
    .i_wdata   (r_wdata),
    .i_rdata   (bus.inMemRData),
    .o_byte_en (w_byte_en),
    .o_wdata   (w_wdata_rep),
    .o_rdata   (w_rdata_ext)
  );

  always_ff @(posedge inClk or negedge inRst) begin
    if (!inRst) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next            = r_state;
    bus.outStall      = w_accept | w_busy;
    bus.outMemReq     = w_busy;
    bus.outMemWrite   = w_busy & r_write;
    bus.outMemAdr     = w_busy ? {r_adr, 2'b00} : '0;
    bus.outMemByteEn  = w_busy ? w_byte_en : 4'b0000;
    bus.outMemWData   = w_busy ? w_wdata_rep : '0;
    bus.outRespValid  = 1'b0;
    bus.outRespData   = '0;
    bus.outTrap       = 1'b0;
    bus.outTrapCode   = c_TRAP_NONE;
    case (r_state)
      IDLE: if (w_accept) w_next = (w_chk_code != c_TRAP_NONE) ? TRAP : BUSY;
      BUSY: begin
        if (bus.inMemAck)   w_next = DONE;
        else if (w_tmo_hit) w_next = TRAP;
      end
      DONE: begin
        w_next           = IDLE;
        bus.outRespValid = ~r_flushed & ~bus.inFlush;
        bus.outRespData  = r_rdata;
      end
      TRAP: begin
        w_next       = IDLE;
        bus.outTrap  = ~r_flushed & ~bus.inFlush;
        bus.outTrapCode = bus.outTrap ? r_trap_code : c_TRAP_NONE;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge inClk or negedge inRst) begin
    if (!inRst) begin
      r_flushed   <= 1'b0;
      r_write     <= 1'b0;
      r_size      <= c_SIZE_BYTE;
      r_off       <= 2'b00;
      r_trap_code <= c_TRAP_NONE;
      r_adr       <= '0;
      r_wdata     <= '0;
      r_rdata     <= '0;
    end else begin
      case (r_state)
        IDLE: if (w_accept) begin
          r_write     <= bus.inReqWrite;
          r_size      <= bus.inReqSize;
          r_off       <= bus.inReqAdr[1:0];
          r_adr       <= bus.inReqAdr[WORD_LENGTH-1:2];
          r_wdata     <= bus.inReqData;
          r_trap_code <= w_chk_code;
        end
        BUSY: begin
          // A squashed access still completes its handshake; only the response is dropped.
          r_flushed <= r_flushed | bus.inFlush;
          if (bus.inMemAck)   r_rdata     <= r_write ? '0 : w_rdata_ext;
          else if (w_tmo_hit) r_trap_code <= c_TRAP_TIMEOUT;
        end
        default: r_flushed <= 1'b0;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_ma_mem_sequencer.sv
//==============================================================================
// tb_ma_mem_sequencer : directed self-checking bench for ma_mem_sequencer
// Rev 1.0
//==============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_ma_mem_sequencer;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_total = 0;
  int   n_bad   = 0;

  always #5 clk = ~clk;

  ma_mem_sequencer_if #(.WORD_LENGTH(32)) bus ();

  ma_mem_sequencer #(.WORD_LENGTH(32), .TIMEOUT_CYCLES(4)) dut (
    .inClk (clk),
    .inRst (rst_n),
    .bus   (bus)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_idle();
    bus.inReqValid = 1'b0;
    bus.inReqWrite = 1'b0;
    bus.inReqSize  = 2'b00;
    bus.inReqAdr   = '0;
    bus.inReqData  = '0;
    bus.inFlush    = 1'b0;
    bus.inMemAck   = 1'b0;
    bus.inMemRData = '0;
  endtask

  task automatic drive_req(input logic w, input logic [1:0] sz,
                           input logic [31:0] adr, input logic [31:0] data);
    bus.inReqValid = 1'b1;
    bus.inReqWrite = w;
    bus.inReqSize  = sz;
    bus.inReqAdr   = adr;
    bus.inReqData  = data;
  endtask

  task automatic ack(input logic [31:0] rdata);
    bus.inMemAck   = 1'b1;
    bus.inMemRData = rdata;
  endtask

  // Word load with ack in the first BUSY cycle; checks the response cycle.
  task automatic word_load(input string tag, input logic [31:0] adr, input logic [31:0] rdata);
    drive_req(1'b0, 2'b10, adr, 32'h0);
    #1 chk({tag, "_c0_stall"}, 32'(bus.outStall), 32'd1);
    tick();
    chk({tag, "_c1_req"}, 32'(bus.outMemReq), 32'd1);
    chk({tag, "_c1_adr"}, bus.outMemAdr, adr);
    chk({tag, "_c1_be"},  32'(bus.outMemByteEn), 32'hF);
    ack(rdata);
    tick();
    drive_idle();
    #1 chk({tag, "_c2_rv"},   32'(bus.outRespValid), 32'd1);
    chk({tag, "_c2_data"},    bus.outRespData, rdata);
    chk({tag, "_c2_stall"},   32'(bus.outStall), 32'd0);
    tick();
    chk({tag, "_c3_rv"},      32'(bus.outRespValid), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got=timeout exp=finish");
    $fatal(1);
  end

  initial begin
    drive_idle();
    tick();
    tick();
    chk("rst_stall", 32'(bus.outStall), 32'd0);
    chk("rst_req",   32'(bus.outMemReq), 32'd0);
    chk("rst_rv",    32'(bus.outRespValid), 32'd0);
    chk("rst_trap",  32'(bus.outTrap), 32'd0);
    chk("rst_be",    32'(bus.outMemByteEn), 32'd0);
    rst_n = 1'b1;
    tick();

    word_load("wload", 32'h0000_1004, 32'hDEAD_BEEF);

    // Byte store at offset 3, ack in the third BUSY cycle
    drive_req(1'b1, 2'b00, 32'h0000_2003, 32'h0000_00A5);
    tick();
    chk("bst_be",    32'(bus.outMemByteEn), 32'h1);
    chk("bst_wdata", bus.outMemWData, 32'hA5A5_A5A5);
    chk("bst_wr",    32'(bus.outMemWrite), 32'd1);
    chk("bst_adr",   bus.outMemAdr, 32'h0000_2000);
    tick();
    chk("bst_c2_req",   32'(bus.outMemReq), 32'd1);
    chk("bst_c2_stall", 32'(bus.outStall), 32'd1);
    tick();
    ack(32'hFFFF_FFFF);
    tick();
    drive_idle();
    #1 chk("bst_rv", 32'(bus.outRespValid), 32'd1);
    chk("bst_data",  bus.outRespData, 32'h0);
    tick();

    // Half load at offset 2
    drive_req(1'b0, 2'b01, 32'h0000_0102, 32'h0);
    tick();
    chk("hld_be", 32'(bus.outMemByteEn), 32'h3);
    ack(32'h1122_3344);
    tick();
    drive_idle();
    #1 chk("hld_rv", 32'(bus.outRespValid), 32'd1);
    chk("hld_data",  bus.outRespData, 32'h0000_3344);
    tick();

    // Byte load at offset 1
    drive_req(1'b0, 2'b00, 32'h0000_2001, 32'h0);
    tick();
    chk("bld_be", 32'(bus.outMemByteEn), 32'h4);
    ack(32'h1122_3344);
    tick();
    drive_idle();
    #1 chk("bld_data", bus.outRespData, 32'h0000_0022);
    tick();

    // Misaligned half
    drive_req(1'b0, 2'b01, 32'h0000_0101, 32'h0);
    #1 chk("mis_c0_stall", 32'(bus.outStall), 32'd1);
    tick();
    drive_idle();
    #1 chk("mis_trap", 32'(bus.outTrap), 32'd1);
    chk("mis_code",    32'(bus.outTrapCode), 32'd1);
    chk("mis_req",     32'(bus.outMemReq), 32'd0);
    chk("mis_stall",   32'(bus.outStall), 32'd0);
    tick();
    chk("mis_c2_trap", 32'(bus.outTrap), 32'd0);

    // Illegal size
    drive_req(1'b0, 2'b11, 32'h0000_0010, 32'h0);
    tick();
    drive_idle();
    #1 chk("ill_trap", 32'(bus.outTrap), 32'd1);
    chk("ill_code",    32'(bus.outTrapCode), 32'd3);
    tick();

    // Flush while BUSY: handshake still completes, no response
    drive_req(1'b0, 2'b10, 32'h0000_3000, 32'h0);
    tick();
    bus.inFlush = 1'b1;
    #1 chk("fl_c1_stall", 32'(bus.outStall), 32'd1);
    tick();
    drive_idle();
    #1 chk("fl_c2_req", 32'(bus.outMemReq), 32'd1);
    ack(32'h1234_5678);
    tick();
    drive_idle();
    #1 chk("fl_c3_rv", 32'(bus.outRespValid), 32'd0);
    tick();
    chk("fl_c4_req",   32'(bus.outMemReq), 32'd0);
    chk("fl_c4_stall", 32'(bus.outStall), 32'd0);

`ifdef MA_SEQ_TIMEOUT_EN
    // No ack: four BUSY cycles then a timeout trap
    drive_req(1'b0, 2'b10, 32'h0000_5000, 32'h0);
    for (int i = 1; i <= 4; i++) begin
      tick();
      chk("tmo_busy_req", 32'(bus.outMemReq), 32'd1);
    end
    tick();
    drive_idle();
    #1 chk("tmo_req", 32'(bus.outMemReq), 32'd0);
    chk("tmo_trap",   32'(bus.outTrap), 32'd1);
    chk("tmo_code",   32'(bus.outTrapCode), 32'd2);
    tick();
    // Ack on the limit cycle wins
    drive_req(1'b0, 2'b10, 32'h0000_5004, 32'h0);
    tick();
    tick();
    tick();
    tick();
    ack(32'hCAFE_F00D);
    tick();
    drive_idle();
    #1 chk("tmo_ack_rv", 32'(bus.outRespValid), 32'd1);
    chk("tmo_ack_data",  bus.outRespData, 32'hCAFE_F00D);
    chk("tmo_ack_trap",  32'(bus.outTrap), 32'd0);
    tick();
`endif

    // Asynchronous reset mid-BUSY
    drive_req(1'b0, 2'b10, 32'h0000_6000, 32'h0);
    tick();
    chk("ar_busy_req", 32'(bus.outMemReq), 32'd1);
    drive_idle();
    rst_n = 1'b0;
    #1 chk("ar_req", 32'(bus.outMemReq), 32'd0);
    chk("ar_stall",  32'(bus.outStall), 32'd0);
    chk("ar_adr",    bus.outMemAdr, 32'h0);
    tick();
    rst_n = 1'b1;
    tick();
    word_load("ar_wload", 32'h0000_4008, 32'h0102_0304);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
